// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: feeds two WIDTH-bit operands to an external
// combinational 2-bit adder one slice per cycle (LSB first). It chains
// the carry through a register and returns the assembled sum over a
// valid/ready handshake.
// Optional build macro: SERIAL_ADD_SUB_EN adds the in_sub port, which
// makes the block compute A-B.
module serial_add_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             in_sub,
`endif
  output logic [1:0]       add_a,
  output logic [1:0]       add_b,
  output logic             add_cin,
  input  logic [1:0]       add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int unsigned N    = WIDTH / 2;
  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state,     w_state_nxt;
  logic [WIDTH-1:0]  r_a,         w_a_nxt;
  logic [WIDTH-1:0]  r_b,         w_b_nxt;
  logic [WIDTH-1:0]  r_result,    w_result_nxt;
  logic [IDXW-1:0]   r_idx,       w_idx_nxt;
  logic              r_carry,     w_carry_nxt;
  logic              r_in_ready,  w_in_ready_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic [WIDTH-1:0]  r_out_sum,   w_out_sum_nxt;
  logic              r_out_cout,  w_out_cout_nxt;
  logic [WIDTH-1:0]  w_b_load;
  logic              w_cin_load;
  logic [WIDTH-1:0]  w_result_shift;

  // Operand B / carry-in as loaded at acceptance (inverted B for subtract)
  always_comb begin
    w_b_load   = in_b;
    w_cin_load = in_cin;
`ifdef SERIAL_ADD_SUB_EN
    if (in_sub) begin
      w_b_load   = ~in_b;
      w_cin_load = 1'b1;
    end
`endif
  end

  // Result accumulates from the top; after N slices slice 0 sits at the LSB
  assign w_result_shift = (r_result >> 2) | (WIDTH'(add_sum) << (WIDTH - 2));

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_result_nxt    = r_result;
    w_idx_nxt       = r_idx;
    w_carry_nxt     = r_carry;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
    w_out_sum_nxt   = r_out_sum;
    w_out_cout_nxt  = r_out_cout;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_nxt    = RUN;
          w_a_nxt        = in_a;
          w_b_nxt        = w_b_load;
          w_carry_nxt    = w_cin_load;
          w_result_nxt   = '0;
          w_idx_nxt      = '0;
          w_in_ready_nxt = 1'b0;
        end
      end
      RUN: begin
        // Operands shift right with zero fill, so they are all-zero once RUN ends
        w_a_nxt      = r_a >> 2;
        w_b_nxt      = r_b >> 2;
        w_result_nxt = w_result_shift;
        w_idx_nxt    = r_idx + IDXW'(1);
        w_carry_nxt  = add_cout;
        if (r_idx == LAST_IDX) begin
          w_state_nxt     = DONE;
          w_idx_nxt       = '0;
          w_carry_nxt     = 1'b0;
          w_out_valid_nxt = 1'b1;
          w_out_sum_nxt   = w_result_shift;
          w_out_cout_nxt  = add_cout;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt     = IDLE;
          w_in_ready_nxt  = 1'b1;
          w_out_valid_nxt = 1'b0;
          w_out_sum_nxt   = '0;
          w_out_cout_nxt  = 1'b0;
          w_result_nxt    = '0;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_in_ready_nxt  = 1'b1;
        w_out_valid_nxt = 1'b0;
        w_out_sum_nxt   = '0;
        w_out_cout_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_cout  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_result    <= w_result_nxt;
      r_idx       <= w_idx_nxt;
      r_carry     <= w_carry_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_sum   <= w_out_sum_nxt;
      r_out_cout  <= w_out_cout_nxt;
    end
  end

  // Adder-side registers read zero outside RUN, so these are direct taps
  assign add_a     = r_a[1:0];
  assign add_b     = r_b[1:0];
  assign add_cin   = r_carry;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_cout  = r_out_cout;

endmodule
